// File: rtl/nand_op_sequencer_if.sv
// Operation / write-data / byte-stream bundle between the op issuer and the
// NAND operation sequencer. The issuer side also drives RB (already
// synchronized to CLK upstream).
interface nand_op_sequencer_if;
  logic        OP_VALID;
  logic        OP_READY;
  logic [1:0]  OP_CODE;
  logic [15:0] OP_COL;
  logic [23:0] OP_ROW;
  logic [7:0]  WR_DATA;
  logic        WR_VALID;
  logic        WR_READY;
  logic        RB;
  logic [7:0]  IOH;
  logic [1:0]  TYPE;
  logic        BYTE_STB;
  logic        BUSY;
  logic        DONE;
  logic        TIMEOUT;

  modport master (
    output OP_VALID, OP_CODE, OP_COL, OP_ROW, WR_DATA, WR_VALID, RB,
    input  OP_READY, WR_READY, IOH, TYPE, BYTE_STB, BUSY, DONE, TIMEOUT
  );

  modport slave (
    input  OP_VALID, OP_CODE, OP_COL, OP_ROW, WR_DATA, WR_VALID, RB,
    output OP_READY, WR_READY, IOH, TYPE, BYTE_STB, BUSY, DONE, TIMEOUT
  );
endinterface

// File: rtl/nand_op_sequencer.sv
// NAND operation sequencer: expands one high-level op (reset, page read,
// page program, block erase) into a paced command/address/data byte stream
// for the pin-level cycle driver, then waits tWB and polls RB (with timeout).
module nand_op_sequencer #(
  parameter int CYCLE_GAP  = 3,
  parameter int PAGE_BYTES = 4320,
  parameter int TWB_CYCLES = 10,
  parameter int RB_TIMEOUT = 65535
) (
  input  logic               CLK,
  input  logic               nRST,
  nand_op_sequencer_if.slave bus
);
  localparam int GW   = (CYCLE_GAP < 1) ? 1 : $clog2(CYCLE_GAP + 1);
  localparam int WMAX = (RB_TIMEOUT > TWB_CYCLES) ? RB_TIMEOUT : TWB_CYCLES;
  localparam int WW   = (WMAX < 1) ? 1 : $clog2(WMAX + 1);

  localparam logic [1:0] OP_RST   = 2'b00;
  localparam logic [1:0] OP_PROG  = 2'b10;
  localparam logic [1:0] OP_ERASE = 2'b11;
  localparam logic [1:0] T_CMD    = 2'b00;
  localparam logic [1:0] T_ADDR   = 2'b01;
  localparam logic [1:0] T_DATA   = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE, S_CMD1, S_ADDR, S_DATA, S_CMD2, S_TWB, S_WAIT_RB, S_FIN
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  op_q, op_d;
  logic [15:0] col_q, col_d;
  logic [23:0] row_q, row_d;
  logic [12:0] cnt_q, cnt_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [WW-1:0] wait_q, wait_d;
  logic [7:0]  ioh_q, ioh_d;
  logic [1:0]  type_q, type_d;
  logic        stb_q, stb_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        timeout_q, timeout_d;
  logic        op_ready_q, op_ready_d;

  logic        wr_ready;
  logic [12:0] cnt_inc;
  logic [7:0]  addr_byte;

  function automatic logic [7:0] cmd1_byte(input logic [1:0] op);
    case (op)
      2'b00:   return 8'hFF;
      2'b01:   return 8'h00;
      2'b10:   return 8'h80;
      default: return 8'h60;
    endcase
  endfunction

  function automatic logic [7:0] cmd2_byte(input logic [1:0] op);
    case (op)
      2'b01:   return 8'h30;
      2'b10:   return 8'h10;
      2'b11:   return 8'hD0;
      default: return 8'hFF;
    endcase
  endfunction

  // Data handshake only once the previous byte's driver cycle has elapsed.
  assign wr_ready = (state_q == S_DATA) && (gap_q == '0);
  assign cnt_inc  = cnt_q + 13'd1;

  // Address byte select: COL low/high, then ROW low/mid/high.
  always_comb begin
    case (cnt_q[2:0])
      3'd0:    addr_byte = col_q[7:0];
      3'd1:    addr_byte = col_q[15:8];
      3'd2:    addr_byte = row_q[7:0];
      3'd3:    addr_byte = row_q[15:8];
      default: addr_byte = row_q[23:16];
    endcase
  end

  // Next-state and next-output computation for the sequencer FSM.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    col_d      = col_q;
    row_d      = row_q;
    cnt_d      = cnt_q;
    gap_d      = (gap_q != '0) ? gap_q - GW'(1) : '0;
    wait_d     = wait_q;
    ioh_d      = ioh_q;
    type_d     = type_q;
    stb_d      = 1'b0;
    busy_d     = busy_q;
    done_d     = 1'b0;
    timeout_d  = timeout_q;
    op_ready_d = op_ready_q;
    case (state_q)
      S_IDLE: begin
        op_ready_d = 1'b1;
        if (bus.OP_VALID && op_ready_q) begin
          op_d       = bus.OP_CODE;
          col_d      = bus.OP_COL;
          row_d      = bus.OP_ROW;
          cnt_d      = (bus.OP_CODE == OP_ERASE) ? 13'd2 : 13'd0;
          busy_d     = 1'b1;
          op_ready_d = 1'b0;
          timeout_d  = 1'b0;
          state_d    = S_CMD1;
        end
      end
      S_CMD1: if (gap_q == '0) begin
        ioh_d   = cmd1_byte(op_q);
        type_d  = T_CMD;
        stb_d   = 1'b1;
        gap_d   = GW'(CYCLE_GAP);
        wait_d  = '0;
        state_d = (op_q == OP_RST) ? S_TWB : S_ADDR;
      end
      S_ADDR: if (gap_q == '0) begin
        ioh_d  = addr_byte;
        type_d = T_ADDR;
        stb_d  = 1'b1;
        gap_d  = GW'(CYCLE_GAP);
        if (cnt_q == 13'd4) begin
          cnt_d   = '0;
          state_d = (op_q == OP_PROG) ? S_DATA : S_CMD2;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_DATA: if (wr_ready && bus.WR_VALID) begin
        ioh_d  = bus.WR_DATA;
        type_d = T_DATA;
        stb_d  = 1'b1;
        gap_d  = GW'(CYCLE_GAP);
        cnt_d  = cnt_inc;
        if (cnt_inc == 13'(PAGE_BYTES)) state_d = S_CMD2;
      end
      S_CMD2: if (gap_q == '0) begin
        ioh_d   = cmd2_byte(op_q);
        type_d  = T_CMD;
        stb_d   = 1'b1;
        gap_d   = GW'(CYCLE_GAP);
        wait_d  = '0;
        state_d = S_TWB;
      end
      S_TWB: begin
        if (wait_q == WW'(TWB_CYCLES - 1)) begin
          wait_d  = '0;
          state_d = S_WAIT_RB;
        end else begin
          wait_d = wait_q + WW'(1);
        end
      end
      S_WAIT_RB: begin
        if (bus.RB) begin
          done_d    = 1'b1;
          busy_d    = 1'b0;
          timeout_d = 1'b0;
          state_d   = S_FIN;
        end else if (wait_q == WW'(RB_TIMEOUT - 1)) begin
          done_d    = 1'b1;
          busy_d    = 1'b0;
          timeout_d = 1'b1;
          state_d   = S_FIN;
        end else begin
          wait_d = wait_q + WW'(1);
        end
      end
      S_FIN: begin
        cnt_d      = '0;
        wait_d     = '0;
        op_ready_d = 1'b1;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and registered outputs; reset aborts any op immediately.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q    <= S_IDLE;
      op_q       <= '0;
      col_q      <= '0;
      row_q      <= '0;
      cnt_q      <= '0;
      gap_q      <= '0;
      wait_q     <= '0;
      ioh_q      <= '0;
      type_q     <= '0;
      stb_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      timeout_q  <= 1'b0;
      op_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      col_q      <= col_d;
      row_q      <= row_d;
      cnt_q      <= cnt_d;
      gap_q      <= gap_d;
      wait_q     <= wait_d;
      ioh_q      <= ioh_d;
      type_q     <= type_d;
      stb_q      <= stb_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      timeout_q  <= timeout_d;
      op_ready_q <= op_ready_d;
    end
  end

  assign bus.OP_READY = op_ready_q;
  assign bus.WR_READY = wr_ready;
  assign bus.IOH      = ioh_q;
  assign bus.TYPE     = type_q;
  assign bus.BYTE_STB = stb_q;
  assign bus.BUSY     = busy_q;
  assign bus.DONE     = done_q;
  assign bus.TIMEOUT  = timeout_q;
endmodule

// File: tb/tb_nand_op_sequencer.sv
// Scoreboard bench for nand_op_sequencer: stimulus pushes expected strobes
// and DONE events; a negedge monitor pops and compares them.
module tb_nand_op_sequencer;
  localparam int GAP = 3, PB = 4, TWB = 10, RBT = 100;

  logic CLK = 1'b0;
  logic nRST = 1'b0;
  always #5 CLK = ~CLK;

  nand_op_sequencer_if sif();

  nand_op_sequencer #(
    .CYCLE_GAP(GAP), .PAGE_BYTES(PB), .TWB_CYCLES(TWB), .RB_TIMEOUT(RBT)
  ) dut (
    .CLK (CLK),
    .nRST(nRST),
    .bus (sif)
  );

  typedef struct { logic [7:0] b; logic [1:0] t; int gap; } stb_t;
  typedef struct { logic to; int dly; } done_t;

  stb_t  exp_q[$];
  done_t exp_done_q[$];

  int n_chk = 0, n_fail = 0;
  int cyc = 0, acc_cyc = 0, last_stb_cyc = 0, done_cyc = 0;
  int n_stb = 0, n_done = 0;

  always @(posedge CLK) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_stb(input logic [7:0] b, input logic [1:0] t, input int gap);
    stb_t e;
    e.b = b; e.t = t; e.gap = gap;
    exp_q.push_back(e);
  endtask

  task automatic push_done(input logic to, input int dly);
    done_t d;
    d.to = to; d.dly = dly;
    exp_done_q.push_back(d);
  endtask

  // Monitor: every strobe and DONE is matched against the scoreboard.
  always @(negedge CLK) begin
    stb_t  e;
    done_t d;
    if (nRST) begin
      if (sif.BYTE_STB) begin
        n_stb++;
        if (exp_q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL unexpected_strobe: got IOH %0h expected no strobe", sif.IOH);
        end else begin
          e = exp_q.pop_front();
          chk("ioh", sif.IOH, e.b);
          chk("type", sif.TYPE, e.t);
          if (e.gap == 0) chk("first_stb_lat", cyc - acc_cyc, 1);
          else            chk("stb_gap", cyc - last_stb_cyc, e.gap);
          chk("busy_at_stb", sif.BUSY, 1);
        end
        last_stb_cyc = cyc;
      end
      if (sif.DONE) begin
        n_done++;
        done_cyc = cyc;
        if (exp_done_q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL unexpected_done: got DONE expected none");
        end else begin
          d = exp_done_q.pop_front();
          chk("timeout", sif.TIMEOUT, d.to);
          chk("done_delay", cyc - last_stb_cyc, d.dly);
          chk("busy_at_done", sif.BUSY, 0);
          chk("op_ready_at_done", sif.OP_READY, 0);
        end
      end
    end
  end

  task automatic issue_op(input logic [1:0] c, input logic [15:0] col, input logic [23:0] row);
    int t = 0;
    @(negedge CLK);
    sif.OP_VALID = 1'b1; sif.OP_CODE = c; sif.OP_COL = col; sif.OP_ROW = row;
    while (!sif.OP_READY && t < 1000) begin @(negedge CLK); t++; end
    chk("accept_wait", t < 1000, 1);
    @(posedge CLK); #1;
    acc_cyc = cyc;
    // Scramble inputs: the captured copy must be used.
    sif.OP_VALID = 1'b0; sif.OP_CODE = ~c; sif.OP_COL = ~col; sif.OP_ROW = ~row;
    chk("busy_after_accept", sif.BUSY, 1);
    chk("op_ready_after_accept", sif.OP_READY, 0);
  endtask

  task automatic feed(input logic [7:0] dat, input int stall);
    int t = 0;
    @(negedge CLK);
    while (!sif.WR_READY && t < 200) begin @(negedge CLK); t++; end
    chk("wr_ready_wait", t < 200, 1);
    if (stall > 0) begin
      sif.WR_VALID = 1'b0;
      repeat (stall) @(negedge CLK);
    end
    sif.WR_DATA = dat; sif.WR_VALID = 1'b1;
    @(posedge CLK); #1;
    sif.WR_VALID = 1'b0; sif.WR_DATA = 8'h5A;
  endtask

  task automatic wait_stb(input int n);
    int t = 0;
    while (n_stb < n && t < 2000) begin @(negedge CLK); #1; t++; end
    chk("strobe_wait", n_stb >= n, 1);
  endtask

  task automatic wait_done(input int n);
    int t = 0;
    while (n_done < n && t < 2000) begin @(negedge CLK); #1; t++; end
    chk("done_wait", n_done >= n, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0, d0;
    sif.OP_VALID = 1'b0; sif.OP_CODE = '0; sif.OP_COL = '0; sif.OP_ROW = '0;
    sif.WR_DATA = '0; sif.WR_VALID = 1'b0; sif.RB = 1'b1;

    // Reset values
    repeat (2) @(negedge CLK);
    chk("rst_ioh", sif.IOH, 0);
    chk("rst_type", sif.TYPE, 0);
    chk("rst_stb", sif.BYTE_STB, 0);
    chk("rst_wr_ready", sif.WR_READY, 0);
    chk("rst_busy", sif.BUSY, 0);
    chk("rst_done", sif.DONE, 0);
    chk("rst_timeout", sif.TIMEOUT, 0);
    chk("rst_op_ready", sif.OP_READY, 1);
    nRST = 1'b1;
    repeat (2) @(negedge CLK);

    // Reset op, RB already high
    push_stb(8'hFF, 2'b00, 0);
    push_done(1'b0, TWB + 1);
    issue_op(2'b00, 16'h0, 24'h0);
    wait_done(1);
    @(posedge CLK); #1;
    chk("op_ready_after_fin", sif.OP_READY, 1);

    // Erase, RB low for 50 clocks after the confirm
    sif.RB = 1'b0;
    push_stb(8'h60, 2'b00, 0);
    push_stb(8'h45, 2'b01, GAP + 1);
    push_stb(8'h23, 2'b01, GAP + 1);
    push_stb(8'h01, 2'b01, GAP + 1);
    push_stb(8'hD0, 2'b00, GAP + 1);
    push_done(1'b0, 51);
    // Follow-on reset op requested while the erase is busy
    push_stb(8'hFF, 2'b00, 0);
    push_done(1'b0, TWB + 1);
    s0 = n_stb;
    issue_op(2'b11, 16'hBEEF, 24'h012345);
    sif.OP_VALID = 1'b1; sif.OP_CODE = 2'b00;
    wait_stb(s0 + 5);
    repeat (50) @(negedge CLK);
    sif.RB = 1'b1;
    wait_done(2);
    @(posedge CLK); #1;
    chk("held_op_idle_ready", sif.OP_READY, 1);
    chk("held_op_idle_busy", sif.BUSY, 0);
    @(posedge CLK); #1;
    chk("held_op_accept_busy", sif.BUSY, 1);
    chk("held_op_accept_cycle", cyc - done_cyc, 2);
    acc_cyc = cyc;
    sif.OP_VALID = 1'b0;
    wait_done(3);

    // Page program with a 7-clock WR_VALID stall before A3
    push_stb(8'h80, 2'b00, 0);
    push_stb(8'h10, 2'b01, GAP + 1);
    push_stb(8'h00, 2'b01, GAP + 1);
    push_stb(8'h02, 2'b01, GAP + 1);
    push_stb(8'h01, 2'b01, GAP + 1);
    push_stb(8'h00, 2'b01, GAP + 1);
    push_stb(8'hA1, 2'b10, GAP + 1);
    push_stb(8'hA2, 2'b10, GAP + 1);
    push_stb(8'hA3, 2'b10, GAP + 1 + 7);
    push_stb(8'hA4, 2'b10, GAP + 1);
    push_stb(8'h10, 2'b00, GAP + 1);
    push_done(1'b0, TWB + 1);
    issue_op(2'b10, 16'h0010, 24'h000102);
    feed(8'hA1, 0);
    feed(8'hA2, 0);
    feed(8'hA3, 7);
    feed(8'hA4, 0);
    wait_done(4);

    // Page read with RB stuck low: timeout
    sif.RB = 1'b0;
    push_stb(8'h00, 2'b00, 0);
    push_stb(8'h34, 2'b01, GAP + 1);
    push_stb(8'h12, 2'b01, GAP + 1);
    push_stb(8'hEF, 2'b01, GAP + 1);
    push_stb(8'hCD, 2'b01, GAP + 1);
    push_stb(8'hAB, 2'b01, GAP + 1);
    push_stb(8'h30, 2'b00, GAP + 1);
    push_done(1'b1, TWB + RBT);
    issue_op(2'b01, 16'h1234, 24'hABCDEF);
    wait_done(5);
    sif.RB = 1'b1;
    repeat (3) @(negedge CLK);

    // Program aborted by nRST during the address phase
    s0 = n_stb;
    push_stb(8'h80, 2'b00, 0);
    push_stb(8'h66, 2'b01, GAP + 1);
    push_stb(8'h55, 2'b01, GAP + 1);
    issue_op(2'b10, 16'h5566, 24'h778899);
    wait_stb(s0 + 2);
    #1 nRST = 1'b0;
    #1;
    chk("abort_ioh", sif.IOH, 0);
    chk("abort_type", sif.TYPE, 0);
    chk("abort_busy", sif.BUSY, 0);
    chk("abort_op_ready", sif.OP_READY, 1);
    chk("abort_stb", sif.BYTE_STB, 0);
    exp_q.delete();
    s0 = n_stb; d0 = n_done;
    repeat (3) @(negedge CLK);
    nRST = 1'b1;
    repeat (20) @(negedge CLK);
    chk("abort_no_strobe", n_stb, s0);
    chk("abort_no_done", n_done, d0);
    push_stb(8'hFF, 2'b00, 0);
    push_done(1'b0, TWB + 1);
    issue_op(2'b00, 16'h0, 24'h0);
    wait_done(d0 + 1);

    repeat (10) @(negedge CLK);
    chk("sb_strobes_drained", exp_q.size(), 0);
    chk("sb_done_drained", exp_done_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
